// File: rtl/mcpu_dram_pkg.sv
// Shared definitions for the MCPU DRAM arbiter.
package mcpu_dram_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

endpackage

// File: rtl/mcpu_rr_arb2.sv
// Two-way round-robin pick: under contention the port not granted last time wins.
module mcpu_rr_arb2
  import mcpu_dram_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic grant_valid,
  output logic grant_idx
);

  always_comb begin
    grant_valid = req0 | req1;
    grant_idx   = PORT_CPU;
    if (req0 && req1) begin
      grant_idx = ~last;
    end else if (req1) begin
      grant_idx = PORT_AUX;
    end
  end

endmodule

// File: rtl/mcpu_dram_arbiter.sv
// Two-port DRAM arbiter and access sequencer with a turnaround cycle after every access.
module mcpu_dram_arbiter
  import mcpu_dram_pkg::*;
#(
  parameter int unsigned DRAM_DATA_BITS = 16,
  parameter int unsigned DRAM_ADDR_BITS = 14
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req0,
  input  logic                      req1,
  input  logic                      we0,
  input  logic                      we1,
  input  logic [DRAM_ADDR_BITS-1:0] addr0,
  input  logic [DRAM_ADDR_BITS-1:0] addr1,
  input  logic [DRAM_DATA_BITS-1:0] wdata0,
  input  logic [DRAM_DATA_BITS-1:0] wdata1,
  output logic                      ack0,
  output logic                      ack1,
  output logic [DRAM_DATA_BITS-1:0] rdata0,
  output logic [DRAM_DATA_BITS-1:0] rdata1,
  output logic                      busy,
  output logic [DRAM_ADDR_BITS-1:0] dram_addr,
  output logic                      dram_we,
  output logic                      dram_re,
  inout  logic [DRAM_DATA_BITS-1:0] data_bus
);

  state_t                    state_q, state_d;
  logic                      sel_q;
  logic                      we_q;
  logic                      last_q;
  logic [DRAM_ADDR_BITS-1:0] addr_q;
  logic [DRAM_DATA_BITS-1:0] wdata_q;
  logic [DRAM_DATA_BITS-1:0] rdata0_q;
  logic [DRAM_DATA_BITS-1:0] rdata1_q;
  logic                      grant_valid;
  logic                      grant_idx;
  logic                      in_access;

  mcpu_rr_arb2 u_arb (
    .req0        (req0),
    .req1        (req1),
    .last        (last_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_valid) state_d = ACCESS;
      ACCESS:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch; addr_q doubles as dram_addr, so it holds between accesses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q   <= PORT_CPU;
      we_q    <= 1'b0;
      last_q  <= PORT_AUX;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (state_q == IDLE && grant_valid) begin
      sel_q   <= grant_idx;
      last_q  <= grant_idx;
      we_q    <= (grant_idx == PORT_AUX) ? we1    : we0;
      addr_q  <= (grant_idx == PORT_AUX) ? addr1  : addr0;
      wdata_q <= (grant_idx == PORT_AUX) ? wdata1 : wdata0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else if (state_q == ACCESS && !we_q) begin
      if (sel_q == PORT_AUX) begin
        rdata1_q <= data_bus;
      end else begin
        rdata0_q <= data_bus;
      end
    end
  end

  // Strobes decode straight from state so reset removes them asynchronously.
  always_comb begin
    in_access = (state_q == ACCESS);
    dram_we   = in_access &  we_q;
    dram_re   = in_access & ~we_q;
    ack0      = (state_q == DONE) && (sel_q == PORT_CPU);
    ack1      = (state_q == DONE) && (sel_q == PORT_AUX);
    busy      = (state_q != IDLE);
    dram_addr = addr_q;
    rdata0    = rdata0_q;
    rdata1    = rdata1_q;
  end

  assign data_bus = dram_we ? wdata_q : 'z;

endmodule

// File: tb/tb_mcpu_dram_arbiter.sv
module tb_mcpu_dram_arbiter;

  localparam int DW = 16;
  localparam int AW = 14;
  localparam logic [DW-1:0] PROBE = 16'h5A5A;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1, busy, dram_we, dram_re;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] dram_addr;
  wire  [DW-1:0] data_bus;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  mcpu_dram_arbiter #(.DRAM_DATA_BITS(DW), .DRAM_ADDR_BITS(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req0      (req0),
    .req1      (req1),
    .we0       (we0),
    .we1       (we1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .ack0      (ack0),
    .ack1      (ack1),
    .rdata0    (rdata0),
    .rdata1    (rdata1),
    .busy      (busy),
    .dram_addr (dram_addr),
    .dram_we   (dram_we),
    .dram_re   (dram_re),
    .data_bus  (data_bus)
  );

  always #5 clk = ~clk;

  // DRAM model; a probe pattern is driven whenever neither strobe is active,
  // so any arbiter drive outside a write ACCESS corrupts the observed value.
  assign data_bus = dram_re ? mem[dram_addr] : (!dram_we ? PROBE : 'z);

  always @(posedge clk) begin
    if (dram_we) mem[dram_addr] <= data_bus;
  end

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic          port;
    logic          is_read;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t          sb [$];
  exp_t          e;
  logic [DW-1:0] model_rdata [2];

  // Output monitor: bus discipline every cycle, scoreboard pop on each ack.
  always @(negedge clk) begin
    check("we_re_excl", {31'd0, dram_we & dram_re}, 32'd0);
    if (!dram_we && !dram_re) check("bus_released", {16'd0, data_bus}, {16'd0, PROBE});
    if (ack0 || ack1) begin
      check("ack_onehot", {31'd0, ack0 & ack1}, 32'd0);
      if (sb.size() == 0) begin
        check("spurious_ack", {30'd0, ack1, ack0}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("ack_port", {31'd0, ack1}, {31'd0, e.port});
        if (!e.is_read) e.rdata = model_rdata[e.port];
        check("rdata", {16'd0, e.port ? rdata1 : rdata0}, {16'd0, e.rdata});
        check("rdata_other", {16'd0, e.port ? rdata0 : rdata1}, {16'd0, model_rdata[!e.port]});
        model_rdata[e.port] = e.rdata;
      end
    end
  end

  task automatic push(input logic port, input logic is_read, input logic [DW-1:0] rd);
    exp_t x;
    x.port = port; x.is_read = is_read; x.rdata = rd;
    sb.push_back(x);
  endtask

  task automatic drive(input logic port, input logic r, input logic we,
                       input logic [AW-1:0] a, input logic [DW-1:0] wd);
    if (port) begin req1 = r; we1 = we; addr1 = a; wdata1 = wd; end
    else      begin req0 = r; we0 = we; addr0 = a; wdata0 = wd; end
  endtask

  task automatic hold_reset();
    reset = 1'b1;
    model_rdata[0] = '0;
    model_rdata[1] = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Single access from a negedge; checks the ACCESS cycle and ack latency.
  task automatic do_access(input logic port, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] wd, input logic [DW-1:0] exp_rd);
    int  n;
    bit  seen;
    n = 0; seen = 0;
    push(port, !we, exp_rd);
    drive(port, 1'b1, we, a, wd);
    while (n < 8 && !seen) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        check("acc_addr", {18'd0, dram_addr}, {18'd0, a});
        check("acc_re", {31'd0, dram_re}, {31'd0, !we});
        check("acc_we", {31'd0, dram_we}, {31'd0, we});
        check("acc_busy", {31'd0, busy}, 32'd1);
      end
      if (port ? ack1 : ack0) seen = 1;
    end
    check("ack_latency", n, 2);
    check("ack_idle_port", {31'd0, port ? ack0 : ack1}, 32'd0);
    drive(port, 1'b0, we, a, wd);
  endtask

  int cyc [4];
  int k, n, cnt;

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    mem[14'h0010] = 16'hBEEF;

    // reset state
    reset = 1'b1;
    model_rdata[0] = '0;
    model_rdata[1] = '0;
    @(negedge clk);
    check("rst_ack0", {31'd0, ack0}, 32'd0);
    check("rst_ack1", {31'd0, ack1}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_we", {31'd0, dram_we}, 32'd0);
    check("rst_re", {31'd0, dram_re}, 32'd0);
    check("rst_addr", {18'd0, dram_addr}, 32'd0);
    check("rst_rdata0", {16'd0, rdata0}, 32'd0);
    check("rst_rdata1", {16'd0, rdata1}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // single read
    do_access(1'b0, 1'b0, 14'h0010, 16'h0000, 16'hBEEF);
    @(negedge clk);
    check("post_busy", {31'd0, busy}, 32'd0);
    check("post_ack0", {31'd0, ack0}, 32'd0);
    check("addr_hold", {18'd0, dram_addr}, 32'h0010);

    // write then read at the top address
    do_access(1'b1, 1'b1, 14'h3FFF, 16'h1234, 16'h0000);
    check("mem_3fff", {16'd0, mem[14'h3FFF]}, 32'h1234);
    @(negedge clk);
    do_access(1'b0, 1'b0, 14'h3FFF, 16'h0000, 16'h1234);
    @(negedge clk);

    // contention held from reset
    drive(1'b0, 1'b1, 1'b0, 14'h0010, '0);
    drive(1'b1, 1'b1, 1'b0, 14'h3FFF, '0);
    push(1'b0, 1'b1, 16'hBEEF);
    push(1'b1, 1'b1, 16'h1234);
    push(1'b0, 1'b1, 16'hBEEF);
    push(1'b1, 1'b1, 16'h1234);
    hold_reset();
    k = 0; n = 0;
    while (k < 4 && n < 30) begin
      @(negedge clk);
      n++;
      if (ack0 || ack1) begin
        cyc[k] = n;
        k++;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    check("cont_acks", k, 4);
    for (int i = 1; i < 4; i++) check("ack_spacing", cyc[i] - cyc[i-1], 3);
    repeat (2) @(negedge clk);

    // one-cycle request pulse
    drive(1'b1, 1'b1, 1'b0, 14'h0010, '0);
    push(1'b1, 1'b1, 16'hBEEF);
    @(negedge clk);
    req1 = 1'b0;
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (ack1) cnt++;
    end
    check("early_drop_acks", cnt, 1);

    // reset during a write ACCESS
    mem[14'h0005] = 16'h0000;
    drive(1'b0, 1'b1, 1'b1, 14'h0005, 16'hAAAA);
    @(negedge clk);
    check("mid_we", {31'd0, dram_we}, 32'd1);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_we", {31'd0, dram_we}, 32'd0);
    check("mid_rst_re", {31'd0, dram_re}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_ack0", {31'd0, ack0}, 32'd0);
    check("mid_rst_ack1", {31'd0, ack1}, 32'd0);
    check("mid_rst_addr", {18'd0, dram_addr}, 32'd0);
    check("mid_rst_rdata0", {16'd0, rdata0}, 32'd0);
    check("mid_rst_rdata1", {16'd0, rdata1}, 32'd0);
    req0 = 1'b0;
    model_rdata[0] = '0;
    model_rdata[1] = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("mem_0005", {16'd0, mem[14'h0005]}, 32'd0);
    check("final_busy", {31'd0, busy}, 32'd0);
    check("sb_drain", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
